// File: rtl/pipelined_adder_carry_if.sv
// Handshake bundle for pipelined_adder_carry.
// Purpose: groups the operand-side valid/ready channel and the result-side
//   valid/ready channel of the pipelined add/subtract unit.
// Signals:
//   in_valid / in_ready  : operand handshake (a, b, cin, sub qualified by in_valid)
//   a, b                 : N-bit operands
//   cin                  : carry-in (add) / borrow-in (subtract)
//   sub                  : 0 = a+b+cin, 1 = a-b-cin
//   out_valid / out_ready: result handshake (sum, cout, ovf qualified by out_valid)
//   sum                  : N-bit result modulo 2^N
//   cout                 : carry out of the MSB (subtract: 1 = no borrow)
//   ovf                  : signed overflow
// Modports: master = producer/consumer around the unit, slave = the unit itself.
interface pipelined_adder_carry_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder_carry.sv
// Pipelined N-bit add/subtract unit with carry-in, carry-out and signed
// overflow. The carry chain is cut into STAGES chunks of W = N/STAGES bits;
// each pipeline stage resolves one chunk. Operand bits not yet consumed ride
// forward in shrinking skew registers, finished sum bits accumulate in growing
// deskew registers, so the whole result leaves the last stage aligned.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (clears all valid, data and carries)
//   bus   : pipelined_adder_carry_if.slave (operand and result handshakes)
// Parameters:
//   N      : operand/result width, N >= 1
//   STAGES : pipeline depth / number of carry chunks, 1 <= STAGES <= N,
//            N must be a multiple of STAGES
// Latency STAGES-1 cycles after the accept edge, throughput one op per cycle.
// The whole pipe advances together when the output slot is empty or drained.
module pipelined_adder_carry #(
  parameter int N      = 8,
  parameter int STAGES = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  pipelined_adder_carry_if.slave bus
);

  localparam int W = N / STAGES;

  if ((N < 1) || (STAGES < 1) || (STAGES > N) || ((N % STAGES) != 0)) begin : g_param_check
    $error("pipelined_adder_carry: need N >= 1, 1 <= STAGES <= N and N %% STAGES == 0");
  end

  logic         w_adv;
  logic         w_c0;
  logic [N-1:0] w_b_eff;

  // Subtraction as a + ~b + ~cin: the inverted borrow-in becomes the carry-in.
  assign w_b_eff = bus.sub ? ~bus.b : bus.b;
  assign w_c0    = bus.sub ^ bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // R = operand bits still unresolved when entering stage k (chunk k is the LSBs).
    localparam int R = N - k * W;

    logic [R-1:0]         w_a;
    logic [R-1:0]         w_b;
    logic                 w_ci;
    logic                 w_vi;
    logic [W-1:0]         w_chunk;
    logic                 w_co;
    logic [(k+1)*W-1:0]   w_s_next;
    logic [(k+1)*W-1:0]   r_s;
    logic                 r_c;
    logic                 r_v;

    if (k == 0) begin : g_head
      assign w_a      = bus.a;
      assign w_b      = w_b_eff;
      assign w_ci     = w_c0;
      assign w_vi     = bus.in_valid;
      assign w_s_next = w_chunk;
    end else begin : g_body
      assign w_a      = g_stg[k-1].g_fwd.r_a;
      assign w_b      = g_stg[k-1].g_fwd.r_b;
      assign w_ci     = g_stg[k-1].r_c;
      assign w_vi     = g_stg[k-1].r_v;
      assign w_s_next = {w_chunk, g_stg[k-1].r_s};
    end

    // One W-bit slice of the carry chain.
    assign {w_co, w_chunk} = {1'b0, w_a[W-1:0]} + {1'b0, w_b[W-1:0]} + {{W{1'b0}}, w_ci};

    // ---- stage k register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_vi;
        r_c <= w_co;
        r_s <= w_s_next;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Skew registers: operand bits for the stages still to come.
      logic [R-W-1:0] r_a;
      logic [R-W-1:0] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[R-1:W];
          r_b <= w_b[R-1:W];
        end
      end
    end else begin : g_last
      // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
      logic r_ovf;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_co ^ w_a[W-1] ^ w_b[W-1] ^ w_chunk[W-1];
        end
      end
    end
  end

  // Global stall: the pipe moves only if the output slot is empty or being taken.
  assign w_adv         = !g_stg[STAGES-1].r_v | bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = g_stg[STAGES-1].r_v;
  assign bus.sum       = g_stg[STAGES-1].r_s;
  assign bus.cout      = g_stg[STAGES-1].r_c;
  assign bus.ovf       = g_stg[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_adder_carry.sv
// Bench for pipelined_adder_carry: three instances (STAGES = 4, 1, 8, N = 8)
// receive identical stimulus. A per-instance scoreboard queue receives the
// reference result on every accept and is compared on every consume.
module tb_pipelined_adder_carry;

  localparam int N  = 8;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         d_in_valid;
  logic [N-1:0] d_a;
  logic [N-1:0] d_b;
  logic         d_cin;
  logic         d_sub;
  logic         d_out_ready;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder_carry_if #(.N(N)) if4 ();
  pipelined_adder_carry_if #(.N(N)) if1 ();
  pipelined_adder_carry_if #(.N(N)) if8 ();

  assign if4.in_valid = d_in_valid;  assign if4.a = d_a;  assign if4.b = d_b;
  assign if4.cin = d_cin;  assign if4.sub = d_sub;  assign if4.out_ready = d_out_ready;
  assign if1.in_valid = d_in_valid;  assign if1.a = d_a;  assign if1.b = d_b;
  assign if1.cin = d_cin;  assign if1.sub = d_sub;  assign if1.out_ready = d_out_ready;
  assign if8.in_valid = d_in_valid;  assign if8.a = d_a;  assign if8.b = d_b;
  assign if8.cin = d_cin;  assign if8.sub = d_sub;  assign if8.out_ready = d_out_ready;

  pipelined_adder_carry #(.N(N), .STAGES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  pipelined_adder_carry #(.N(N), .STAGES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  pipelined_adder_carry #(.N(N), .STAGES(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  wire [ND-1:0] ov = {if8.out_valid, if1.out_valid, if4.out_valid};
  wire [ND-1:0] ir = {if8.in_ready,  if1.in_ready,  if4.in_ready};
  wire [ND-1:0] co = {if8.cout,      if1.cout,      if4.cout};
  wire [ND-1:0] of = {if8.ovf,       if1.ovf,       if4.ovf};
  wire [N-1:0]  sm [ND];
  assign sm[0] = if4.sum;
  assign sm[1] = if1.sum;
  assign sm[2] = if8.sum;

  function automatic int stages_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 8);
  endfunction

  // Reference: {ovf, cout, sum}
  function automatic logic [N+1:0] ref_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic cin, input logic sub);
    logic [N-1:0] be;
    logic         c0;
    logic [N:0]   full;
    logic [N-1:0] low;
    be   = sub ? ~b : b;
    c0   = sub ? ~cin : cin;
    full = {1'b0, a} + {1'b0, be} + {{N{1'b0}}, c0};
    low  = {1'b0, a[N-2:0]} + {1'b0, be[N-2:0]} + {{(N-1){1'b0}}, c0};
    return {low[N-1] ^ full[N], full[N], full[N-1:0]};
  endfunction

  logic [N+1:0] sbq [ND][$];
  logic [N+1:0] mon_exp;

  // Scoreboard: pop/compare on consume, push on accept (sampled mid-cycle).
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < ND; d++) begin
        if (ov[d] && d_out_ready) begin
          n_checks++;
          if (sbq[d].size() == 0) begin
            n_err++;
            $display("FAIL sb_extra S=%0d: got sum=%h cout=%b ovf=%b, want no output", stages_of(d), sm[d], co[d], of[d]);
          end else begin
            mon_exp = sbq[d].pop_front();
            if ({of[d], co[d], sm[d]} !== mon_exp) begin
              n_err++;
              $display("FAIL sb_result S=%0d: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                       stages_of(d), of[d], co[d], sm[d], mon_exp[N+1], mon_exp[N], mon_exp[N-1:0]);
            end
          end
        end
        if (d_in_valid && ir[d]) sbq[d].push_back(ref_op(d_a, d_b, d_cin, d_sub));
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if ({ov[d], ir[d], sm[d], co[d], of[d]} !== {1'b0, 1'b1, {N{1'b0}}, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL reset_state S=%0d: got valid=%b ready=%b sum=%h cout=%b ovf=%b, want 0 1 00 0 0",
                 stages_of(d), ov[d], ir[d], sm[d], co[d], of[d]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int t;
    int first [ND];
    logic [N+1:0] want;
    want = {1'b0, 1'b0, 8'h03};
    @(posedge clk); #1;
    d_a = 8'h01; d_b = 8'h02; d_cin = 1'b0; d_sub = 1'b0; d_in_valid = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    t = cyc;
    for (int d = 0; d < ND; d++) first[d] = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (ov[d] && first[d] < 0) begin
          first[d] = cyc;
          n_checks++;
          if ({of[d], co[d], sm[d]} !== want) begin
            n_err++;
            $display("FAIL add_basic S=%0d: got ovf=%b cout=%b sum=%h, want 0 0 03", stages_of(d), of[d], co[d], sm[d]);
          end
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (first[d] != t + stages_of(d) - 1) begin
        n_err++;
        $display("FAIL latency S=%0d: got first valid at cycle %0d, want %0d", stages_of(d), first[d], t + stages_of(d) - 1);
      end
    end
  endtask

  task automatic test_carry_chain();
    logic [N-1:0] va [2];
    logic [N-1:0] vb [2];
    logic         vc [2];
    logic [N+1:0] want [2];
    logic [ND-1:0] seen;
    va = '{8'hFF, 8'h7F}; vb = '{8'h01, 8'h00}; vc = '{1'b0, 1'b1};
    want = '{{1'b0, 1'b1, 8'h00}, {1'b1, 1'b0, 8'h80}};
    for (int v = 0; v < 2; v++) begin
      @(posedge clk); #1;
      d_a = va[v]; d_b = vb[v]; d_cin = vc[v]; d_sub = 1'b0; d_in_valid = 1'b1;
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      seen = '0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
          if (ov[d] && !seen[d]) begin
            seen[d] = 1'b1;
            n_checks++;
            if ({of[d], co[d], sm[d]} !== want[v]) begin
              n_err++;
              $display("FAIL carry_chain%0d S=%0d: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                       v, stages_of(d), of[d], co[d], sm[d], want[v][N+1], want[v][N], want[v][N-1:0]);
            end
          end
        end
      end
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (!seen[d]) begin
          n_err++;
          $display("FAIL carry_chain%0d_timeout S=%0d: got no result, want one", v, stages_of(d));
        end
      end
    end
  endtask

  task automatic test_subtract();
    logic [N-1:0] va [2];
    logic [N-1:0] vb [2];
    logic [N+1:0] want [2];
    logic [ND-1:0] seen;
    va = '{8'h05, 8'h80}; vb = '{8'h07, 8'h01};
    want = '{{1'b0, 1'b0, 8'hFE}, {1'b1, 1'b1, 8'h7F}};
    for (int v = 0; v < 2; v++) begin
      @(posedge clk); #1;
      d_a = va[v]; d_b = vb[v]; d_cin = 1'b0; d_sub = 1'b1; d_in_valid = 1'b1;
      @(posedge clk); #1;
      d_in_valid = 1'b0;
      seen = '0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
          if (ov[d] && !seen[d]) begin
            seen[d] = 1'b1;
            n_checks++;
            if ({of[d], co[d], sm[d]} !== want[v]) begin
              n_err++;
              $display("FAIL subtract%0d S=%0d: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                       v, stages_of(d), of[d], co[d], sm[d], want[v][N+1], want[v][N], want[v][N-1:0]);
            end
          end
        end
      end
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (!seen[d]) begin
          n_err++;
          $display("FAIL subtract%0d_timeout S=%0d: got no result, want one", v, stages_of(d));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int cnt [ND];
    int fst [ND];
    int lst [ND];
    for (int d = 0; d < ND; d++) begin cnt[d] = 0; fst[d] = -1; lst[d] = -1; end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i < 16) begin
        d_a = N'($urandom_range(0, 255)); d_b = N'($urandom_range(0, 255));
        d_cin = 1'($urandom_range(0, 1)); d_sub = 1'($urandom_range(0, 1));
        d_in_valid = 1'b1;
      end else begin
        d_in_valid = 1'b0;
      end
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (ov[d]) begin
          cnt[d]++;
          if (fst[d] < 0) fst[d] = i;
          lst[d] = i;
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (cnt[d] != 16 || lst[d] - fst[d] != 15) begin
        n_err++;
        $display("FAIL back_to_back S=%0d: got %0d results over %0d cycles, want 16 over 16",
                 stages_of(d), cnt[d], lst[d] - fst[d] + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N+1:0] snap [ND];
    d_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      d_a = N'($urandom_range(0, 255)); d_b = N'($urandom_range(0, 255));
      d_cin = 1'($urandom_range(0, 1)); d_sub = 1'($urandom_range(0, 1));
      d_in_valid = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) snap[d] = {of[d], co[d], sm[d]};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        n_checks++;
        if (ir[d] !== 1'b0 || ov[d] !== 1'b1) begin
          n_err++;
          $display("FAIL stall_handshake S=%0d: got in_ready=%b out_valid=%b, want 0 1", stages_of(d), ir[d], ov[d]);
        end
        n_checks++;
        if ({of[d], co[d], sm[d]} !== snap[d]) begin
          n_err++;
          $display("FAIL stall_stable S=%0d: got %h, want %h", stages_of(d), {of[d], co[d], sm[d]}, snap[d]);
        end
      end
    end
    @(posedge clk); #1;
    d_out_ready = 1'b1;
    d_in_valid  = 1'b0;
    repeat (14) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (sbq[d].size() != 0) begin
        n_err++;
        $display("FAIL stall_drain S=%0d: got %0d results outstanding, want 0", stages_of(d), sbq[d].size());
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [ND-1:0] stale;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      d_a = N'($urandom_range(0, 255)); d_b = N'($urandom_range(0, 255));
      d_cin = 1'($urandom_range(0, 1)); d_sub = 1'b0;
      d_in_valid = 1'b1;
    end
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if ({ov[d], ir[d], sm[d], co[d], of[d]} !== {1'b0, 1'b1, {N{1'b0}}, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL midflight_reset S=%0d: got valid=%b ready=%b sum=%h cout=%b ovf=%b, want 0 1 00 0 0",
                 stages_of(d), ov[d], ir[d], sm[d], co[d], of[d]);
      end
      sbq[d].delete();
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = '0;
    repeat (15) begin
      @(negedge clk);
      stale = stale | ov;
    end
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (stale[d] !== 1'b0) begin
        n_err++;
        $display("FAIL stale_after_reset S=%0d: got out_valid=1, want 0", stages_of(d));
      end
    end
  endtask

  initial begin
    d_in_valid = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_sub = 1'b0; d_out_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    test_reset();
    test_latency();
    test_carry_chain();
    test_subtract();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_latency();
    repeat (4) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      n_checks++;
      if (sbq[d].size() != 0) begin
        n_err++;
        $display("FAIL final_drain S=%0d: got %0d results outstanding, want 0", stages_of(d), sbq[d].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
